// File: rtl/ps2_pkg.sv
// ps2_pkg: types and constants shared by the PS/2 host transmitter and the PS/2 receiver.
//   ps2_tx_state_e : transmitter FSM encoding
//   FRAME_BITS     : host-to-device bits shifted after the start bit (8 data, parity, stop)
//   CMD_* / RSP_*  : keyboard command bytes and device reply bytes
//   odd_parity()   : parity bit that makes the 9-bit {parity, data} word odd
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StReq,
      StShift,
      StAck,
      StWaitIdle
   } ps2_tx_state_e;

   localparam int unsigned FRAME_BITS = 10;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_ECHO    = 8'hEE;
   localparam logic [7:0] CMD_RESET   = 8'hFF;

   localparam logic [7:0] RSP_ACK     = 8'hFA;
   localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: 3-flop synchronizer for an asynchronous PS/2 pin plus a falling-edge pulse.
//   clk_i   : system clock
//   clr_i   : asynchronous active-high reset; chain resets to all ones (idle bus level)
//   pin_i   : raw pin level
//   level_o : synchronized level
//   fall_o  : one-cycle pulse, 2-3 clk after the pin falls
module ps2_edge_sync (
   input  logic clk_i,
   input  logic clr_i,
   input  logic pin_i,
   output logic level_o,
   output logic fall_o
);

   logic [2:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], pin_i};
   end

   always_ff @(posedge clk_i or posedge clr_i) begin
      if (clr_i) begin
         sync_q <= 3'b111;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign level_o = sync_q[2];
   assign fall_o  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter with request-to-send sequencing.
//   clk, clr                : system clock, asynchronous active-high reset
//   ps2_clk_in, ps2_data_in : sensed open-drain pin levels (asynchronous)
//   send, tx_data           : transmit request and command byte (taken when send & ready)
//   ready, busy             : idle / frame in progress (busy = ~ready)
//   ps2_clk_oe, ps2_data_oe : 1 pulls the corresponding line low
//   done, ack_err, timeout  : mutually exclusive one-cycle completion pulses
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   input  logic       send,
   input  logic [7:0] tx_data,
   output logic       ready,
   output logic       busy,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   // One counter serves the inhibit phase and, after REQ, the frame timeout.
   localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   ps2_tx_state_e         state_q, state_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [3:0]            edge_cnt_q, edge_cnt_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [2:0]            data_sync_q, data_sync_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  clk_oe_q, clk_oe_d;
   logic                  data_oe_q, data_oe_d;
   logic                  done_q, done_d;
   logic                  ack_err_q, ack_err_d;
   logic                  timeout_q, timeout_d;

   logic clk_lvl, clk_fall, data_lvl, tmo_hit;

   ps2_edge_sync u_clk_sync (
      .clk_i   (clk),
      .clr_i   (clr),
      .pin_i   (ps2_clk_in),
      .level_o (clk_lvl),
      .fall_o  (clk_fall)
   );

   assign data_lvl = data_sync_q[2];

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      edge_cnt_d  = edge_cnt_q;
      cnt_d       = cnt_q;
      data_sync_d = {data_sync_q[1:0], ps2_data_in};
      ready_d     = ready_q;
      clk_oe_d    = clk_oe_q;
      data_oe_d   = data_oe_q;
      done_d      = 1'b0;
      ack_err_d   = 1'b0;
      timeout_d   = 1'b0;
      tmo_hit     = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

      unique case (state_q)
         StIdle: begin
            // After a pulse ready is still low for one cycle; it rises here.
            ready_d = 1'b1;
            if (send && ready_q) begin
               frame_d    = {1'b1, odd_parity(tx_data), tx_data};
               cnt_d      = '0;
               edge_cnt_d = '0;
               ready_d    = 1'b0;
               clk_oe_d   = 1'b1;
               state_d    = StInhibit;
            end
         end
         StInhibit: begin
            if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
               cnt_d     = '0;
               data_oe_d = 1'b1;
               state_d   = StReq;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StReq: begin
            // Release clock, keep the start bit on data; timeout starts counting now.
            clk_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = StShift;
         end
         StShift: begin
            cnt_d = cnt_q + 1'b1;
            if (clk_fall) begin
               data_oe_d  = ~frame_q[0];
               frame_d    = {1'b0, frame_q[FRAME_BITS-1:1]};
               edge_cnt_d = edge_cnt_q + 4'd1;
               if (edge_cnt_q == 4'(FRAME_BITS - 1)) begin
                  state_d = StAck;
               end
            end
         end
         StAck: begin
            cnt_d = cnt_q + 1'b1;
            if (clk_fall) begin
               if (!data_lvl) begin
                  state_d = StWaitIdle;
               end else begin
                  ack_err_d  = 1'b1;
                  clk_oe_d   = 1'b0;
                  data_oe_d  = 1'b0;
                  cnt_d      = '0;
                  edge_cnt_d = '0;
                  state_d    = StIdle;
               end
            end
         end
         StWaitIdle: begin
            cnt_d = cnt_q + 1'b1;
            if (clk_lvl && data_lvl) begin
               done_d     = 1'b1;
               cnt_d      = '0;
               edge_cnt_d = '0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Timeout overrides any same-cycle ack decision.
      if ((state_q inside {StShift, StAck, StWaitIdle}) && tmo_hit) begin
         done_d     = 1'b0;
         ack_err_d  = 1'b0;
         timeout_d  = 1'b1;
         clk_oe_d   = 1'b0;
         data_oe_d  = 1'b0;
         cnt_d      = '0;
         edge_cnt_d = '0;
         state_d    = StIdle;
      end

      busy_d = ~ready_d;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= StIdle;
         frame_q     <= '0;
         edge_cnt_q  <= '0;
         cnt_q       <= '0;
         data_sync_q <= 3'b111;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         done_q      <= 1'b0;
         ack_err_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         edge_cnt_q  <= edge_cnt_d;
         cnt_q       <= cnt_d;
         data_sync_q <= data_sync_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
         done_q      <= done_d;
         ack_err_q   <= ack_err_d;
         timeout_q   <= timeout_d;
      end
   end

   assign ready       = ready_q;
   assign busy        = busy_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign done        = done_q;
   assign ack_err     = ack_err_q;
   assign timeout     = timeout_q;

endmodule
